p2s_stream_converter: RTL and testbench
=======================================

Name: p2s_stream_converter

Overview:
- Parametrised parallel-to-serial width converter with valid/ready handshakes on both sides.
- Accepts one P_WIDTH word and emits it as P_WIDTH/S_WIDTH beats of S_WIDTH bits, MSB-first or LSB-first.
- Supports partial words and a one-word holding buffer, so back-to-back words stream with no bubble.
- Sits between the packet/frame builder and the UART TX byte path; it is the handshaked successor of the fixed 64-to-8 shifter.

Parameters:
- P_WIDTH, 64, parallel input width; must be an integer multiple of S_WIDTH.
- S_WIDTH, 8, serial beat width.
- MSB_FIRST, 1, beat order: 1 emits the top slice first, 0 emits bits [S_WIDTH-1:0] first.
- Derived: NBEATS = P_WIDTH/S_WIDTH (must be >= 2); CW = $clog2(NBEATS).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_data/in_len valid.
- in_ready  output  1  converter can accept a word.
- in_data  input  P_WIDTH  parallel word.
- in_len  input  CW  number of beats to emit; 0 means full NBEATS.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  S_WIDTH  current beat.
- out_last  output  1  current beat is the final beat of its word.
- busy  output  1  out_valid OR holding buffer occupied.

Behaviour:
- Reset (rst_n low at a clock edge):
  - out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1.
  - Shift register, hold buffer and beat counter are cleared.
  - Reset mid-word drops all buffered data; no beat is emitted after reset.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- State machine (shift stage):
  - IDLE: out_valid=0 and out_data=0.
  - SHIFT: out_valid=1; out_data is the current slice of the shift register.
  - While out_valid && !out_ready, out_data and out_last are held stable.
- Beat order:
  - MSB_FIRST=1: beat k = word[P_WIDTH-1-k*S_WIDTH -: S_WIDTH].
  - MSB_FIRST=0: beat k = word[k*S_WIDTH +: S_WIDTH].
  - After each output transfer the register shifts by S_WIDTH (zero-fill) and the beat counter increments.
- Beat count:
  - Beats per word L = (in_len==0) ? NBEATS : in_len, latched with the word.
  - Partial words take beats in the same order, from the MSB end when MSB_FIRST=1 and from the LSB end when 0.
  - out_last=1 exactly when beat counter == L-1 and out_valid=1.
- Hold buffer: one word plus its length, with a hold_valid flag.
  - in_ready = !hold_valid (registered, no combinational path from out_ready).
- Load rules on an input transfer:
  - Shift stage empty, or its last beat transferring this cycle: the word goes straight to the shift register.
  - Otherwise the word goes to the hold buffer.
- Final-beat transfer with hold_valid=1: the hold word loads into the shift register in the same cycle, hold_valid clears, and out_valid stays 1. No bubble.
- Final-beat transfer with hold empty and no input transfer: the shift stage returns to IDLE next cycle.
- Latency: word accepted at edge N; first beat on out_data after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle sustained when out_ready=1 and words arrive on time.
- Full: shift stage active and hold_valid=1 gives in_ready=0; in_valid is ignored.
- Simultaneous events: input accept plus final-beat output in the same cycle follows the load rules above. Ordering is never reversed.

Optional Feature:
- Macro: P2S_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = XOR of out_data, aligned to and held with out_data.
  - Adds output par_err_cnt (8 bits, saturating) that counts output transfers where out_parity != ^out_data. This is a self-check and must stay 0 in a correct implementation.
  - Both outputs reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: P=32, S=8, MSB_FIRST=1, rst_n low 2 cycles -> out_valid=0, out_data=0, busy=0, in_ready=1.
- Single full word: in_data=32'hA1B2C3D4, in_len=0, out_ready=1 -> beats A1,B2,C3,D4 on 4 consecutive cycles starting the cycle after accept; out_last only on D4.
- LSB-first plus partial: MSB_FIRST=0, in_data=32'h11223344, in_len=2 -> beats 44,33; out_last on 33; IDLE next cycle.
- Back-pressure:
  - Word 32'hDEADBEEF with out_ready low for 3 cycles at beat 2 -> out_data=AD held for 3 cycles, no beat lost or duplicated.
  - A second word offered meanwhile is accepted into hold, then in_ready=0.
- Streaming: words 32'h01020304 and 32'h05060708 back-to-back, out_ready=1 -> 8 beats 01..08 on 8 consecutive cycles with no bubble; two out_last pulses.
- Reset mid-word: assert rst_n low after beat 2 of a word with hold occupied -> next cycle out_valid=0, busy=0, in_ready=1; no stale beats after release.

Source files
------------

// File: rtl/p2s_stream_converter.sv
// p2s_stream_converter: parallel-to-serial width converter with valid/ready
// handshakes on both sides. One P_WIDTH word is emitted as up to
// P_WIDTH/S_WIDTH beats of S_WIDTH bits (MSB-first or LSB-first). A one-word
// holding buffer lets back-to-back words stream without a bubble.
// Optional feature macro: P2S_PARITY_EN adds out_parity and par_err_cnt.
module p2s_stream_converter #(
    parameter int P_WIDTH   = 64,
    parameter int S_WIDTH   = 8,
    parameter int MSB_FIRST = 1,
    localparam int NBEATS   = P_WIDTH / S_WIDTH,
    localparam int CW       = $clog2(NBEATS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [P_WIDTH-1:0] in_data,
    input  logic [CW-1:0]      in_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [S_WIDTH-1:0] out_data,
    output logic               out_last,
    output logic               busy
`ifdef P2S_PARITY_EN
    ,
    output logic               out_parity,
    output logic [7:0]         par_err_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [P_WIDTH-1:0] shift_r, shift_s;
    logic [P_WIDTH-1:0] hold_data_r, hold_data_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [CW-1:0]      last_r, last_s;
    logic [CW-1:0]      hold_last_r, hold_last_s;
    logic               hold_valid_r, hold_valid_s;
    logic [CW-1:0]      in_last_s;
    logic               in_xfer_s, out_xfer_s, final_xfer_s;
    logic               out_valid_s, out_last_s, in_ready_s, busy_s;
    logic [S_WIDTH-1:0] out_data_s;

    // Beat currently presented by the shift register.
    function automatic logic [S_WIDTH-1:0] slice_f(input logic [P_WIDTH-1:0] w);
        if (MSB_FIRST != 32'sd0) begin
            return w[P_WIDTH-1 -: S_WIDTH];
        end else begin
            return w[S_WIDTH-1:0];
        end
    endfunction

    // Advance the shift register by one beat, zero-filling the vacated slice.
    function automatic logic [P_WIDTH-1:0] shift_f(input logic [P_WIDTH-1:0] w);
        if (MSB_FIRST != 32'sd0) begin
            return w << S_WIDTH;
        end else begin
            return w >> S_WIDTH;
        end
    endfunction

    // Handshake qualifiers and the index of the final beat of an incoming word.
    always_comb begin
        in_xfer_s    = in_valid && in_ready;
        out_xfer_s   = out_valid && out_ready;
        final_xfer_s = out_xfer_s && (cnt_r == last_r);
        if (in_len == CW'(0)) begin
            in_last_s = CW'(NBEATS - 1);
        end else begin
            in_last_s = in_len - CW'(1);
        end
    end

    // Shift-stage and hold-buffer next state.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        cnt_s        = cnt_r;
        last_s       = last_r;
        hold_data_s  = hold_data_r;
        hold_last_s  = hold_last_r;
        hold_valid_s = hold_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (in_xfer_s) begin
                    state_s = ST_SHIFT;
                    shift_s = in_data;
                    cnt_s   = CW'(0);
                    last_s  = in_last_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (final_xfer_s) begin
                    if (hold_valid_r) begin
                        // Hold word follows immediately: no bubble.
                        shift_s      = hold_data_r;
                        last_s       = hold_last_r;
                        cnt_s        = CW'(0);
                        hold_valid_s = 1'b0;
                        hold_data_s  = {P_WIDTH{1'b0}};
                        hold_last_s  = CW'(0);
                    end else if (in_xfer_s) begin
                        shift_s = in_data;
                        last_s  = in_last_s;
                        cnt_s   = CW'(0);
                    end else begin
                        state_s = ST_IDLE;
                        shift_s = {P_WIDTH{1'b0}};
                        cnt_s   = CW'(0);
                        last_s  = CW'(0);
                    end
                end else begin
                    if (out_xfer_s) begin
                        shift_s = shift_f(shift_r);
                        cnt_s   = cnt_r + CW'(1);
                    end else begin
                        shift_s = shift_r;
                        cnt_s   = cnt_r;
                    end
                    if (in_xfer_s) begin
                        hold_data_s  = in_data;
                        hold_last_s  = in_last_s;
                        hold_valid_s = 1'b1;
                    end else begin
                        hold_valid_s = hold_valid_r;
                    end
                end
            end
            default: begin
                state_s      = ST_IDLE;
                shift_s      = {P_WIDTH{1'b0}};
                cnt_s        = CW'(0);
                last_s       = CW'(0);
                hold_valid_s = 1'b0;
            end
        endcase
    end

    // Output values derived from the next state so the ports come from flops.
    always_comb begin
        out_valid_s = (state_s == ST_SHIFT);
        if (out_valid_s) begin
            out_data_s = slice_f(shift_s);
            out_last_s = (cnt_s == last_s);
        end else begin
            out_data_s = {S_WIDTH{1'b0}};
            out_last_s = 1'b0;
        end
        in_ready_s = !hold_valid_s;
        busy_s     = out_valid_s || hold_valid_s;
    end

    // State, datapath and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shift_r      <= {P_WIDTH{1'b0}};
            cnt_r        <= CW'(0);
            last_r       <= CW'(0);
            hold_data_r  <= {P_WIDTH{1'b0}};
            hold_last_r  <= CW'(0);
            hold_valid_r <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= {S_WIDTH{1'b0}};
            out_last     <= 1'b0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            cnt_r        <= cnt_s;
            last_r       <= last_s;
            hold_data_r  <= hold_data_s;
            hold_last_r  <= hold_last_s;
            hold_valid_r <= hold_valid_s;
            out_valid    <= out_valid_s;
            out_data     <= out_data_s;
            out_last     <= out_last_s;
            in_ready     <= in_ready_s;
            busy         <= busy_s;
        end
    end

`ifdef P2S_PARITY_EN
    // Even parity over one beat.
    function automatic logic parity_f(input logic [S_WIDTH-1:0] d);
        return ^d;
    endfunction

    // Parity travels with out_data; the error counter self-checks it per beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_parity  <= 1'b0;
            par_err_cnt <= 8'd0;
        end else begin
            out_parity <= parity_f(out_data_s);
            if (out_xfer_s && (out_parity != parity_f(out_data)) && (par_err_cnt != 8'hFF)) begin
                par_err_cnt <= par_err_cnt + 8'd1;
            end else begin
                par_err_cnt <= par_err_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_p2s_stream_converter.sv
// Bench for p2s_stream_converter: two instances (MSB-first and LSB-first,
// P=32, S=8) share one stimulus stream and run in lockstep. A scoreboard
// queues expected beats on every accepted word; directed sequences cover the
// multi-cycle corners and a table of vectors covers partial lengths under
// random back-pressure.
module tb_p2s_stream_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_len;
    logic        out_ready;
    logic        rnd_en;

    logic        m_in_ready, m_out_valid, m_out_last, m_busy;
    logic [7:0]  m_out_data;
    logic        l_in_ready, l_out_valid, l_out_last, l_busy;
    logic [7:0]  l_out_data;
`ifdef P2S_PARITY_EN
    logic        m_out_parity, l_out_parity;
    logic [7:0]  m_par_err_cnt, l_par_err_cnt;
`endif

    always #5 clk = ~clk;

    p2s_stream_converter #(.P_WIDTH(32), .S_WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_len(in_len), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_data(m_out_data), .out_last(m_out_last),
        .busy(m_busy)
`ifdef P2S_PARITY_EN
        , .out_parity(m_out_parity), .par_err_cnt(m_par_err_cnt)
`endif
    );

    p2s_stream_converter #(.P_WIDTH(32), .S_WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .in_len(in_len), .out_valid(l_out_valid),
        .out_ready(out_ready), .out_data(l_out_data), .out_last(l_out_last),
        .busy(l_busy)
`ifdef P2S_PARITY_EN
        , .out_parity(l_out_parity), .par_err_cnt(l_par_err_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int lasts_seen = 0;
    logic [8:0] exp_m_q[$];
    logic [8:0] exp_l_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] held_m_d, held_l_d;
    logic       held_m_l, held_l_l;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  len;
        int          nb;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop/compare on output transfers, push on input transfers.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_m", {m_out_last, m_out_data}, {held_m_l, held_m_d});
                check("stall_hold_l", {l_out_last, l_out_data}, {held_l_l, held_l_d});
            end
            if (m_out_valid && out_ready) begin
                if (exp_m_q.size() == 0 || exp_l_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_beat: got %0h with empty queue", m_out_data);
                end else begin
                    check("sb_beat_m", {m_out_last, m_out_data}, exp_m_q.pop_front());
                    check("sb_beat_l", {l_out_last, l_out_data}, exp_l_q.pop_front());
                end
                beats_seen++;
                if (m_out_last) lasts_seen++;
`ifdef P2S_PARITY_EN
                check("parity_m", m_out_parity, ^m_out_data);
                check("parity_l", l_out_parity, ^l_out_data);
`endif
            end
            stall_prev = m_out_valid && !out_ready;
            held_m_d = m_out_data;
            held_m_l = m_out_last;
            held_l_d = l_out_data;
            held_l_l = l_out_last;
            if (in_valid && m_in_ready) begin
                int nb;
                nb = (in_len == 2'd0) ? 4 : int'(in_len);
                for (int k = 0; k < nb; k++) begin
                    exp_m_q.push_back({(k == nb - 1), in_data[31 - 8 * k -: 8]});
                    exp_l_q.push_back({(k == nb - 1), in_data[8 * k +: 8]});
                end
            end
        end
    end

    // Random back-pressure while enabled.
    always @(posedge clk) begin
        #1;
        if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Global time guard.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] len);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = len;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!m_busy && exp_m_q.size() == 0) break;
        end
        check("drain_busy", m_busy, 1'b0);
        check("drain_queue", exp_m_q.size(), 0);
        tick();
    endtask

    // Single word with out_ready=1; exp_* hold beat k at [31-8k -: 8].
    task automatic do_direct(input logic [31:0] d, input logic [1:0] len,
                             input logic [31:0] exp_m, input logic [31:0] exp_l, input int n);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = len;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("dir_valid", m_out_valid, 1'b1);
            check("dir_data_m", m_out_data, exp_m[31 - 8 * k -: 8]);
            check("dir_data_l", l_out_data, exp_l[31 - 8 * k -: 8]);
            check("dir_last", {m_out_last, l_out_last}, (k == n - 1) ? 2'b11 : 2'b00);
            tick();
        end
        @(negedge clk);
        check("dir_idle_valid", {m_out_valid, l_out_valid}, 2'b00);
        check("dir_idle_data", m_out_data, 8'h00);
        tick();
    endtask

    initial begin
        int total;
        int base_beats;
        int base_lasts;
        logic [7:0] exp_s;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_len    = 2'd0;
        out_ready = 1'b1;
        rnd_en    = 1'b0;

        // Reset / idle
        tick();
        tick();
        @(negedge clk);
        check("rst_out_valid", {m_out_valid, l_out_valid}, 2'b00);
        check("rst_out_data", m_out_data, 8'h00);
        check("rst_out_last", m_out_last, 1'b0);
        check("rst_busy", m_busy, 1'b0);
        check("rst_in_ready", {m_in_ready, l_in_ready}, 2'b11);
`ifdef P2S_PARITY_EN
        check("rst_parity", {m_out_parity, m_par_err_cnt}, 9'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // Single full word, then LSB-first partial word
        do_direct(32'hA1B2C3D4, 2'd0, 32'hA1B2C3D4, 32'hD4C3B2A1, 4);
        do_direct(32'h11223344, 2'd2, 32'h11220000, 32'h44330000, 2);

        // Back-pressure at beat 2 with a second word landing in hold
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_len   = 2'd0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_beat0_m", m_out_data, 8'hDE);
        check("bp_beat0_l", l_out_data, 8'hEF);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_held_m", m_out_data, 8'hAD);
            check("bp_held_l", l_out_data, 8'hBE);
            check("bp_valid", m_out_valid, 1'b1);
            check("bp_in_ready", m_in_ready, (i == 0) ? 1'b1 : 1'b0);
            check("bp_busy", m_busy, 1'b1);
            tick();
            if (i == 0) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        wait_drain();

        // Streaming: two words back-to-back, no bubble
        in_valid = 1'b1;
        in_data  = 32'h01020304;
        in_len   = 2'd0;
        tick();
        in_data  = 32'h05060708;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_s = 8'(k + 1);
            check("stream_valid", m_out_valid, 1'b1);
            check("stream_data_m", m_out_data, exp_s);
            exp_s = (k < 4) ? 8'(4 - k) : 8'(12 - k);
            check("stream_data_l", l_out_data, exp_s);
            check("stream_last", m_out_last, (k == 3 || k == 7) ? 1'b1 : 1'b0);
            tick();
            if (k == 0) in_valid = 1'b0;
        end
        @(negedge clk);
        check("stream_idle", m_out_valid, 1'b0);
        tick();

        // Table of words under random back-pressure
        tbl[0] = '{32'h0BADF00D, 2'd0, 4};
        tbl[1] = '{32'h12345678, 2'd1, 1};
        tbl[2] = '{32'h9ABCDEF0, 2'd3, 3};
        tbl[3] = '{32'hFFFFFFFF, 2'd2, 2};
        tbl[4] = '{32'h00000000, 2'd0, 4};
        tbl[5] = '{32'h80000001, 2'd1, 1};
        tbl[6] = '{32'h5A5AA5A5, 2'd0, 4};
        tbl[7] = '{32'hC3C3C3C3, 2'd3, 3};
        total      = 0;
        base_beats = beats_seen;
        base_lasts = lasts_seen;
        rnd_en     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].data, tbl[i].len);
            total += tbl[i].nb;
            if ($urandom_range(0, 1) == 1) tick();
        end
        rnd_en = 1'b0;
        tick();
        out_ready = 1'b1;
        wait_drain();
        check("tbl_beats", beats_seen - base_beats, total);
        check("tbl_lasts", lasts_seen - base_lasts, 8);

        // Reset mid-word with hold occupied
        in_valid = 1'b1;
        in_data  = 32'h13579BDF;
        in_len   = 2'd0;
        tick();
        in_data  = 32'h2468ACE0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_pre_in_ready", m_in_ready, 1'b0);
        check("mid_pre_busy", m_busy, 1'b1);
        tick();
        rst_n = 1'b1;
        exp_m_q.delete();
        exp_l_q.delete();
        @(negedge clk);
        check("mid_out_valid", {m_out_valid, l_out_valid}, 2'b00);
        check("mid_busy", m_busy, 1'b0);
        check("mid_in_ready", m_in_ready, 1'b1);
        check("mid_out_data", m_out_data, 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            check("mid_no_stale", {m_out_valid, l_out_valid}, 2'b00);
        end
        tick();

        // Post-reset word still works
        do_direct(32'h0F1E2D3C, 2'd3, 32'h0F1E2D00, 32'h3C2D1E00, 3);

        check("end_queue", exp_m_q.size() + exp_l_q.size(), 0);
`ifdef P2S_PARITY_EN
        check("end_par_err", {m_par_err_cnt, l_par_err_cnt}, 16'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
